reg_scoreboard: RTL and testbench



---
 rtl/cpu_pkg.sv | 20 ++
 rtl/sb_hazard_check.sv | 61 ++++++
 rtl/reg_scoreboard.sv | 128 ++++++++++++
 tb/tb_reg_scoreboard.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the issue-side register scoreboard.
//   ADDR_W   : register address width
//   NUM_REGS : number of architectural registers tracked
//   MAX_OUT  : maximum tracked writes in flight
//   CNT_W    : width of the outstanding-write counter (holds 0..MAX_OUT)
//   sb_state_t : scoreboard drain FSM encoding
package cpu_pkg;

    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int MAX_OUT  = 4;
    localparam int CNT_W    = 3;

    typedef enum logic [1:0] {
        SB_RUN   = 2'd0,
        SB_DRAIN = 2'd1,
        SB_DONE  = 2'd2
    } sb_state_t;

endpackage

// File: rtl/sb_hazard_check.sv
// Combinational hazard evaluation for one issuing instruction.
// Ports:
//   busy        : pending-write bit vector (bit 0 is always clear)
//   rs/rt/rd    : source and destination addresses of the issuing instr
//   uses_rt     : instr reads RT
//   writes_rd   : instr writes RD through a tracked unit
//   wb_valid/wb_addr : writeback happening this cycle
//   outstanding : current in-flight write count
//   raw_hazard  : RS/RT read blocked by a pending write
//   waw_hazard  : RD already has a pending write
//   full_hazard : RD write would exceed the in-flight limit
//   wb_clear    : this cycle's writeback retires a pending write
module sb_hazard_check
    import cpu_pkg::*;
(
    input  logic [NUM_REGS-1:0] busy,
    input  logic [ADDR_W-1:0]   rs,
    input  logic [ADDR_W-1:0]   rt,
    input  logic [ADDR_W-1:0]   rd,
    input  logic                uses_rt,
    input  logic                writes_rd,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [CNT_W-1:0]    outstanding,
    output logic                raw_hazard,
    output logic                waw_hazard,
    output logic                full_hazard,
    output logic                wb_clear
);

    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

    logic wb_hit_rs;
    logic wb_hit_rt;
    logic haz_rs;
    logic haz_rt;
    logic rd_tracked;
    logic full;

    // The register file writes on negedge, so a writeback in the same
    // cycle delivers the value in time for the read: bypass the hazard.
    assign wb_hit_rs = wb_valid && (wb_addr == rs) && (rs != '0);
    assign wb_hit_rt = wb_valid && (wb_addr == rt) && (rt != '0);

    assign haz_rs = busy[rs] & ~wb_hit_rs;
    assign haz_rt = busy[rt] & ~wb_hit_rt;

    assign raw_hazard = haz_rs | (uses_rt & haz_rt);

    assign wb_clear = wb_valid & busy[wb_addr];

    // A retiring writeback frees a slot in the same cycle.
    assign full = (outstanding == MAX_OUT_C) & ~wb_clear;

    // WAW deliberately ignores the writeback bypass: the set and clear
    // of the same bit must never collide on one edge.
    assign rd_tracked  = writes_rd & (rd != '0);
    assign waw_hazard  = rd_tracked & busy[rd];
    assign full_hazard = rd_tracked & full;

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side scoreboard for the 32x32 register file. Tracks destinations
// of in-flight multi-cycle writes, stalls decode on RAW/WAW hazards and on
// the in-flight limit, and offers a drain handshake.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   issue_valid_i           : decode presents an instruction
//   RSaddr_i/RTaddr_i/RDaddr_i : operand/destination addresses
//   uses_rt_i, writes_rd_i  : instruction attributes
//   stall_o, issue_ack_o    : combinational issue handshake
//   wb_valid_i, wb_addr_i   : tracked-unit writeback
//   drain_i, drain_done_o   : drain request / completion (registered)
//   busy_o, outstanding_o   : pending-write vector and count (registered)
//   err_o                   : sticky writeback protocol error
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    input  logic [ADDR_W-1:0]   RSaddr_i,
    input  logic [ADDR_W-1:0]   RTaddr_i,
    input  logic [ADDR_W-1:0]   RDaddr_i,
    input  logic                uses_rt_i,
    input  logic                writes_rd_i,
    output logic                stall_o,
    output logic                issue_ack_o,
    input  logic                wb_valid_i,
    input  logic [ADDR_W-1:0]   wb_addr_i,
    input  logic                drain_i,
    output logic                drain_done_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [CNT_W-1:0]    outstanding_o,
    output logic                err_o
);

    sb_state_t           state_q;
    sb_state_t           state_d;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                err_q;
    logic                done_q;

    logic raw_hazard;
    logic waw_hazard;
    logic full_hazard;
    logic wb_clear;
    logic accept;

    sb_hazard_check u_hazard (
        .busy        (busy_q),
        .rs          (RSaddr_i),
        .rt          (RTaddr_i),
        .rd          (RDaddr_i),
        .uses_rt     (uses_rt_i),
        .writes_rd   (writes_rd_i),
        .wb_valid    (wb_valid_i),
        .wb_addr     (wb_addr_i),
        .outstanding (cnt_q),
        .raw_hazard  (raw_hazard),
        .waw_hazard  (waw_hazard),
        .full_hazard (full_hazard),
        .wb_clear    (wb_clear)
    );

    assign stall_o = issue_valid_i &
                     (raw_hazard | waw_hazard | full_hazard | (state_q != SB_RUN));
    assign issue_ack_o = issue_valid_i & ~stall_o;
    assign accept      = issue_ack_o & writes_rd_i & (RDaddr_i != '0);

    // Clear of the retiring bit and set of the newly issued bit may land
    // on the same edge; they never target the same register.
    always_comb begin
        busy_d = busy_q;
        if (wb_clear) begin
            busy_d[wb_addr_i] = 1'b0;
        end
        if (accept) begin
            busy_d[RDaddr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, wb_clear})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_RUN:   if (drain_i)        state_d = SB_DRAIN;
            SB_DRAIN: if (cnt_d == '0)    state_d = SB_DONE;
            SB_DONE:  if (!drain_i)       state_d = SB_RUN;
            default:                      state_d = SB_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SB_RUN;
            busy_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_d == SB_DONE);
            // Writeback to an idle or zero register is a protocol error.
            if (wb_valid_i && !busy_q[wb_addr_i]) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy_o        = busy_q;
    assign outstanding_o = cnt_q;
    assign err_o         = err_q;
    assign drain_done_o  = done_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;
    import cpu_pkg::*;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                issue_valid_i;
    logic [ADDR_W-1:0]   RSaddr_i;
    logic [ADDR_W-1:0]   RTaddr_i;
    logic [ADDR_W-1:0]   RDaddr_i;
    logic                uses_rt_i;
    logic                writes_rd_i;
    logic                stall_o;
    logic                issue_ack_o;
    logic                wb_valid_i;
    logic [ADDR_W-1:0]   wb_addr_i;
    logic                drain_i;
    logic                drain_done_o;
    logic [NUM_REGS-1:0] busy_o;
    logic [CNT_W-1:0]    outstanding_o;
    logic                err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    reg_scoreboard dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .issue_valid_i (issue_valid_i),
        .RSaddr_i      (RSaddr_i),
        .RTaddr_i      (RTaddr_i),
        .RDaddr_i      (RDaddr_i),
        .uses_rt_i     (uses_rt_i),
        .writes_rd_i   (writes_rd_i),
        .stall_o       (stall_o),
        .issue_ack_o   (issue_ack_o),
        .wb_valid_i    (wb_valid_i),
        .wb_addr_i     (wb_addr_i),
        .drain_i       (drain_i),
        .drain_done_o  (drain_done_o),
        .busy_o        (busy_o),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        issue_valid_i = 1'b0;
        RSaddr_i      = '0;
        RTaddr_i      = '0;
        RDaddr_i      = '0;
        uses_rt_i     = 1'b0;
        writes_rd_i   = 1'b0;
        wb_valid_i    = 1'b0;
        wb_addr_i     = '0;
    endtask

    task automatic issue(input int rs, input int rt, input bit urt, input int rd, input bit wr);
        issue_valid_i = 1'b1;
        RSaddr_i      = ADDR_W'(rs);
        RTaddr_i      = ADDR_W'(rt);
        uses_rt_i     = urt;
        RDaddr_i      = ADDR_W'(rd);
        writes_rd_i   = wr;
    endtask

    task automatic wb(input int a);
        wb_valid_i = 1'b1;
        wb_addr_i  = ADDR_W'(a);
    endtask

    initial begin
        idle();
        drain_i = 1'b0;
        rst_i   = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        #1;
        check("rst_busy", busy_o, 32'h0);
        check("rst_out", 32'(outstanding_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_done", 32'(drain_done_o), 0);
        check("rst_stall", 32'(stall_o), 0);

        // Basic set, RAW stall, writeback bypass
        issue(0, 0, 0, 5, 1);
        #1;
        check("rd5_stall", 32'(stall_o), 0);
        check("rd5_ack", 32'(issue_ack_o), 1);
        step();
        idle();
        #1;
        check("rd5_busy", busy_o, 32'h0000_0020);
        check("rd5_out", 32'(outstanding_o), 1);
        issue(5, 0, 0, 0, 0);
        #1;
        check("raw5_stall", 32'(stall_o), 1);
        check("raw5_ack", 32'(issue_ack_o), 0);
        step();
        #1;
        check("raw5_stall2", 32'(stall_o), 1);
        wb(5);
        #1;
        check("byp5_stall", 32'(stall_o), 0);
        check("byp5_ack", 32'(issue_ack_o), 1);
        step();
        idle();
        #1;
        check("byp5_busy", busy_o, 32'h0);
        check("byp5_out", 32'(outstanding_o), 0);

        // RT gating and WAW not bypassed
        issue(0, 0, 0, 7, 1);
        step();
        idle();
        issue(0, 7, 0, 0, 0);
        #1;
        check("rt_unused", 32'(stall_o), 0);
        uses_rt_i = 1'b1;
        #1;
        check("rt_used", 32'(stall_o), 1);
        idle();
        issue(0, 0, 0, 7, 1);
        wb(7);
        #1;
        check("waw_nobyp", 32'(stall_o), 1);
        step();
        idle();
        #1;
        check("waw_busy", busy_o, 32'h0);
        check("waw_out", 32'(outstanding_o), 0);

        // Register zero is never tracked
        for (int i = 0; i < 3; i++) begin
            issue(0, 0, 1, 0, 1);
            #1;
            check("r0_stall", 32'(stall_o), 0);
            step();
        end
        idle();
        #1;
        check("r0_busy", busy_o, 32'h0);
        check("r0_out", 32'(outstanding_o), 0);

        // Fill the in-flight limit, then free a slot in the same cycle
        for (int r = 1; r <= 4; r++) begin
            issue(0, 0, 0, r, 1);
            #1;
            check("fill_ack", 32'(issue_ack_o), 1);
            step();
        end
        idle();
        #1;
        check("fill_out", 32'(outstanding_o), 4);
        check("fill_busy", busy_o, 32'h0000_001E);
        issue(0, 0, 0, 6, 1);
        #1;
        check("full_stall", 32'(stall_o), 1);
        wb(1);
        #1;
        check("full_free_ack", 32'(issue_ack_o), 1);
        step();
        idle();
        #1;
        check("full_out", 32'(outstanding_o), 4);
        check("full_busy", busy_o, 32'h0000_005C);
        check("full_err", 32'(err_o), 0);

        // Retire two, then drain the remaining two (regs 4 and 6)
        wb(2);
        step();
        wb(3);
        step();
        idle();
        #1;
        check("pre_drain_out", 32'(outstanding_o), 2);
        drain_i = 1'b1;
        issue(0, 0, 0, 0, 0);
        #1;
        check("drain_req_ack", 32'(issue_ack_o), 1);
        step();
        #1;
        check("drain_stall", 32'(stall_o), 1);
        check("drain_done0", 32'(drain_done_o), 0);
        wb(4);
        step();
        #1;
        check("drain_done1", 32'(drain_done_o), 0);
        check("drain_out1", 32'(outstanding_o), 1);
        wb(6);
        step();
        wb_valid_i = 1'b0;
        #1;
        check("drain_done2", 32'(drain_done_o), 1);
        check("drain_out2", 32'(outstanding_o), 0);
        check("drain_busy2", busy_o, 32'h0);
        check("done_stall", 32'(stall_o), 1);
        drain_i = 1'b0;
        step();
        #1;
        check("resume_done", 32'(drain_done_o), 0);
        check("resume_stall", 32'(stall_o), 0);
        idle();

        // Spurious writeback sets sticky error
        wb(9);
        step();
        idle();
        #1;
        check("err_set", 32'(err_o), 1);
        check("err_busy", busy_o, 32'h0);
        step();
        #1;
        check("err_sticky", 32'(err_o), 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        check("err_clr", 32'(err_o), 0);

        // Reset with a write in flight, then a late writeback
        issue(0, 0, 0, 10, 1);
        step();
        idle();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        check("rst_fl_busy", busy_o, 32'h0);
        check("rst_fl_out", 32'(outstanding_o), 0);
        wb(10);
        step();
        idle();
        #1;
        check("late_wb_err", 32'(err_o), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
